// File: rtl/audio_softmute_if.sv
// Sample/control bundle between the core audio outputs, the soft-mute stage and the DAC.
// The master modport drives samples, enable and mute; the slave modport drives DAC codes and status.
interface audio_softmute_if #(
    parameter int WIDTH     = 16,
    parameter int GAIN_BITS = 8
);
    logic                 ce;
    logic                 mute;
    logic [WIDTH-1:0]     in_l;
    logic [WIDTH-1:0]     in_r;
    logic [WIDTH-1:0]     d_l;
    logic [WIDTH-1:0]     d_r;
    logic                 active;
    logic [GAIN_BITS:0]   gain;

    modport master (
        output ce, mute, in_l, in_r,
        input  d_l, d_r, active, gain
    );

    modport slave (
        input  ce, mute, in_l, in_r,
        output d_l, d_r, active, gain
    );
endinterface

// File: rtl/audio_softmute.sv
// Click-free soft mute: a linear gain ramp with power-up holdoff, applied to both channels,
// followed by signed-to-offset-binary conversion for the DAC. Two ce ticks of datapath latency.
module audio_softmute #(
    parameter int WIDTH     = 16,
    parameter int GAIN_BITS = 8,
    parameter int STEP_DIV  = 256,
    parameter int HOLDOFF   = 65536
) (
    input  logic          clk,
    input  logic          reset_n,
    audio_softmute_if.slave bus
);
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int PROD_W = WIDTH + GAIN_BITS + 1;

    localparam logic [GAIN_BITS:0] GAIN_ZERO = {(GAIN_BITS+1){1'b0}};
    localparam logic [GAIN_BITS:0] GAIN_ONE  = {{GAIN_BITS{1'b0}}, 1'b1};
    localparam logic [GAIN_BITS:0] GAIN_MAX  = {1'b1, {GAIN_BITS{1'b0}}};
    localparam logic [HOLD_W-1:0]  HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLDOFF - 1);
    localparam logic [STEP_W-1:0]  STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [WIDTH-1:0]   MIDSCALE  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_MUTED     = 3'd0,
        ST_HOLDOFF   = 3'd1,
        ST_RAMP_UP   = 3'd2,
        ST_RUN       = 3'd3,
        ST_RAMP_DOWN = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [GAIN_BITS:0]  gain_r, gain_s;
    logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
    logic [STEP_W-1:0]   step_cnt_r, step_cnt_s;
    logic                active_r, active_s;
    logic                step_done_s;

    logic signed [WIDTH-1:0]  s1_l_r, s1_r_r;
    logic [GAIN_BITS:0]       s1_gain_r;
    logic signed [PROD_W-1:0] gain_ext_s, prod_l_s, prod_r_s;
    logic [WIDTH-1:0]         d_l_r, d_r_r, d_l_s, d_r_s;
    logic                     unused_s;

    // Next-state, gain step and counter logic for the mute sequencer.
    always_comb begin
        state_s     = state_r;
        gain_s      = gain_r;
        hold_cnt_s  = hold_cnt_r;
        step_cnt_s  = step_cnt_r;
        step_done_s = (step_cnt_r == STEP_LAST);
        case (state_r)
            ST_MUTED: begin
                gain_s     = GAIN_ZERO;
                hold_cnt_s = HOLD_ZERO;
                if (!bus.mute) begin
                    state_s = ST_HOLDOFF;
                end else begin
                    state_s = ST_MUTED;
                end
            end
            ST_HOLDOFF: begin
                gain_s = GAIN_ZERO;
                if (bus.mute) begin
                    state_s = ST_MUTED;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_s = ST_RAMP_UP;
                end else begin
                    hold_cnt_s = hold_cnt_r + HOLD_ONE;
                end
            end
            ST_RAMP_UP: begin
                if (bus.mute) begin
                    state_s = ST_RAMP_DOWN;
                end else if (gain_r == GAIN_MAX) begin
                    state_s = ST_RUN;
                end else if (step_done_s) begin
                    gain_s     = gain_r + GAIN_ONE;
                    step_cnt_s = STEP_ZERO;
                    if (gain_r == (GAIN_MAX - GAIN_ONE)) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_RAMP_UP;
                    end
                end else begin
                    step_cnt_s = step_cnt_r + STEP_ONE;
                end
            end
            ST_RUN: begin
                gain_s = GAIN_MAX;
                if (bus.mute) begin
                    state_s = ST_RAMP_DOWN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RAMP_DOWN: begin
                if (!bus.mute) begin
                    state_s = ST_RAMP_UP;
                end else if (gain_r == GAIN_ZERO) begin
                    state_s = ST_MUTED;
                end else if (step_done_s) begin
                    gain_s     = gain_r - GAIN_ONE;
                    step_cnt_s = STEP_ZERO;
                    if (gain_r == GAIN_ONE) begin
                        state_s = ST_MUTED;
                    end else begin
                        state_s = ST_RAMP_DOWN;
                    end
                end else begin
                    step_cnt_s = step_cnt_r + STEP_ONE;
                end
            end
            default: begin
                state_s    = ST_MUTED;
                gain_s     = GAIN_ZERO;
                hold_cnt_s = HOLD_ZERO;
            end
        endcase
        // Every state entry restarts the step divider.
        if (state_s != state_r) begin
            step_cnt_s = STEP_ZERO;
        end else begin
            step_cnt_s = step_cnt_s;
        end
        active_s = (state_s == ST_RAMP_UP) || (state_s == ST_RUN) || (state_s == ST_RAMP_DOWN);
    end

    // Sequencer state, gain and counter registers, advanced on ce only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_MUTED;
            gain_r     <= GAIN_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            step_cnt_r <= STEP_ZERO;
            active_r   <= 1'b0;
        end else if (bus.ce) begin
            state_r    <= state_s;
            gain_r     <= gain_s;
            hold_cnt_r <= hold_cnt_s;
            step_cnt_r <= step_cnt_s;
            active_r   <= active_s;
        end
    end

    // Gain multiply with floor division by unity, then MSB flip to offset binary.
    always_comb begin
        gain_ext_s = PROD_W'($signed({1'b0, s1_gain_r}));
        prod_l_s   = PROD_W'(s1_l_r) * gain_ext_s;
        prod_r_s   = PROD_W'(s1_r_r) * gain_ext_s;
        d_l_s      = {~prod_l_s[GAIN_BITS+WIDTH-1], prod_l_s[GAIN_BITS+WIDTH-2:GAIN_BITS]};
        d_r_s      = {~prod_r_s[GAIN_BITS+WIDTH-1], prod_r_s[GAIN_BITS+WIDTH-2:GAIN_BITS]};
        unused_s   = ^{prod_l_s[PROD_W-1], prod_l_s[GAIN_BITS-1:0],
                       prod_r_s[PROD_W-1], prod_r_s[GAIN_BITS-1:0]};
    end

    // Two-stage sample pipeline; both channels share the same captured gain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_l_r    <= {WIDTH{1'b0}};
            s1_r_r    <= {WIDTH{1'b0}};
            s1_gain_r <= GAIN_ZERO;
            d_l_r     <= MIDSCALE;
            d_r_r     <= MIDSCALE;
        end else if (bus.ce) begin
            s1_l_r    <= bus.in_l;
            s1_r_r    <= bus.in_r;
            s1_gain_r <= gain_r;
            d_l_r     <= d_l_s;
            d_r_r     <= d_r_s;
        end
    end

    assign bus.d_l    = d_l_r;
    assign bus.d_r    = d_r_r;
    assign bus.active = active_r;
    assign bus.gain   = gain_r;
endmodule
